// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state codes and default timing constants for the stopwatch
package stopwatch_pkg;

   // State codes are also shown on the debug LEDs, so the encoding is fixed
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_LAP   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_FULL  = 3'd4
   } sw_state_t;

   // 10 ms at 100 MHz; the display mux uses the same values
   localparam int SW_TICK_DIV  = 1_000_000;
   localparam int SW_DB_CYCLES = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchronizer, debounce filter and press-edge detector
module btn_debounce
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = SW_DB_CYCLES
) (
   input  logic clk,
   input  logic r,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int            CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level_q;
   logic          level_d;
   logic          press_q;
   logic [CW-1:0] cnt;

   // Two-flop synchronizer, then accept a new level only after DB_CYCLES
   // consecutive disagreeing cycles; a one-cycle press follows each rising level
   always_ff @(posedge clk) begin
      if (r) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level_q <= 1'b0;
         level_d <= 1'b0;
         press_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level_q;
         press_q <= level_q & ~level_d;
         if (sync2 != level_q) begin
            if (cnt == CNT_LAST) begin
               level_q <= sync2;
               cnt     <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch run/pause/lap/full sequencer with 10 ms tick prescaler
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV  = SW_TICK_DIV,
   parameter int DB_CYCLES = SW_DB_CYCLES
) (
   input  logic       clk,
   input  logic       r,
   input  logic       s,
   input  logic       l,
   input  logic       sat,
   output logic       run,
   output logic       tick,
   output logic       clr,
   output logic       hold,
   output logic [2:0] st
);

   localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   sw_state_t     state;
   sw_state_t     state_nxt;
   logic          clr_nxt;
   logic          start;
   logic          ps;
   logic          pl;
   logic          s_level_unused;
   logic          l_level_unused;
   logic [PW-1:0] presc;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_s (
      .clk   (clk),
      .r     (r),
      .raw   (s),
      .level (s_level_unused),
      .press (ps)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l (
      .clk   (clk),
      .r     (r),
      .raw   (l),
      .level (l_level_unused),
      .press (pl)
   );

   // Next state; sat outranks ps which outranks pl, and losing presses are dropped
   always_comb begin
      state_nxt = state;
      clr_nxt   = 1'b0;
      start     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ps) begin
               state_nxt = ST_RUN;
               start     = 1'b1;
            end
         end
         ST_RUN: begin
            if (sat)     state_nxt = ST_FULL;
            else if (ps) state_nxt = ST_PAUSE;
            else if (pl) state_nxt = ST_LAP;
         end
         ST_LAP: begin
            if (sat)     state_nxt = ST_FULL;
            else if (ps) state_nxt = ST_PAUSE;
            else if (pl) state_nxt = ST_RUN;
         end
         ST_PAUSE: begin
            if (ps) begin
               state_nxt = ST_RUN;
            end else if (pl) begin
               state_nxt = ST_IDLE;
               clr_nxt   = 1'b1;
            end
         end
         ST_FULL: begin
            if (pl) begin
               state_nxt = ST_IDLE;
               clr_nxt   = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register with outputs registered from the next state so they line up with st
   always_ff @(posedge clk) begin
      if (r) begin
         state <= ST_IDLE;
         run   <= 1'b0;
         hold  <= 1'b0;
         clr   <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
         hold  <= (state_nxt == ST_LAP);
         clr   <= clr_nxt;
      end
   end

   // Prescaler runs only while counting and keeps its phase across a pause
   always_ff @(posedge clk) begin
      if (r) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= run && (presc == PRE_LAST);
         if (start) begin
            presc <= '0;
         end else if (run) begin
            presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
         end
      end
   end

   assign st = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - directed self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

   typedef struct {
      bit         use_l;
      logic [2:0] e_st;
      logic       e_run;
      logic       e_hold;
      logic       e_clr;
   } vec_t;

   logic       clk = 1'b0;
   logic       r   = 1'b1;
   logic       s   = 1'b0;
   logic       l   = 1'b0;
   logic       sat = 1'b0;
   logic       run;
   logic       tick;
   logic       clr;
   logic       hold;
   logic [2:0] st;

   int n_tests = 0;
   int n_fail  = 0;

   vec_t       vecs [9];
   logic [2:0] cur;
   int         tick_cnt;

   always #5 clk = ~clk;

   stopwatch_ctrl #(.TICK_DIV(5), .DB_CYCLES(4)) dut (
      .clk  (clk),
      .r    (r),
      .s    (s),
      .l    (l),
      .sat  (sat),
      .run  (run),
      .tick (tick),
      .clr  (clr),
      .hold (hold),
      .st   (st)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string name, input logic [2:0] e_st, input logic e_run,
                           input logic e_hold, input logic e_clr);
      chk({name, ".st"},   32'(st),   32'(e_st));
      chk({name, ".run"},  32'(run),  32'(e_run));
      chk({name, ".hold"}, 32'(hold), 32'(e_hold));
      chk({name, ".clr"},  32'(clr),  32'(e_clr));
   endtask

   // Clean press starting just after edge N; returns just after edge N+8
   task automatic press_go(input bit use_l, input bit sat_late, input logic [2:0] prev);
      if (use_l) l = 1'b1;
      else       s = 1'b1;
      repeat (6) step();
      l = 1'b0;
      s = 1'b0;
      step();
      chk("st_before_transition", 32'(st), 32'(prev));
      if (sat_late) sat = 1'b1;
      step();
   endtask

   task automatic check_ticks(input string name, input int n, input int first);
      logic exp_t;
      for (int i = 1; i <= n; i++) begin
         step();
         exp_t = (first > 0) && (i >= first) && (((i - first) % 5) == 0);
         chk($sformatf("%s[%0d]", name, i), 32'(tick), 32'(exp_t));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 3'd2, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 3'd1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 3'd0, 1'b0, 1'b0, 1'b1};

      // reset state
      r = 1'b1;
      step();
      step();
      chk_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0);
      chk("reset.tick", 32'(tick), 32'(0));
      r = 1'b0;
      step();
      chk_outs("post_reset", 3'd0, 1'b0, 1'b0, 1'b0);

      // table: press sequence through IDLE/RUN/LAP/PAUSE and back to IDLE
      cur = 3'd0;
      for (int i = 0; i < 9; i++) begin
         press_go(vecs[i].use_l, 1'b0, cur);
         chk_outs($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_run, vecs[i].e_hold, vecs[i].e_clr);
         step();
         chk($sformatf("vec%0d.clr_next", i), 32'(clr), 32'(0));
         cur = vecs[i].e_st;
         repeat (5) step();
      end

      // start: tick period 5 from the IDLE->RUN edge
      press_go(1'b0, 1'b0, 3'd0);
      chk_outs("start", 3'd1, 1'b1, 1'b0, 1'b0);
      check_ticks("start_tick", 15, 5);

      // reset mid-RUN
      r = 1'b1;
      step();
      r = 1'b0;
      chk_outs("reset_run", 3'd0, 1'b0, 1'b0, 1'b0);
      step();

      // bounce: four 3-cycle highs never qualify
      repeat (4) begin
         s = 1'b1;
         repeat (3) step();
         s = 1'b0;
         step();
      end
      repeat (4) step();
      chk("bounce.st", 32'(st), 32'(0));
      chk("bounce.run", 32'(run), 32'(0));

      // clean press after bounce, then pause/resume phase accuracy
      press_go(1'b0, 1'b0, 3'd0);
      chk_outs("bounce_press", 3'd1, 1'b1, 1'b0, 1'b0);
      check_ticks("run_tick", 5, 5);
      press_go(1'b0, 1'b0, 3'd1);
      chk_outs("pause", 3'd3, 1'b0, 1'b0, 1'b0);
      check_ticks("pause_notick", 7, 0);
      press_go(1'b0, 1'b0, 3'd3);
      chk_outs("resume", 3'd1, 1'b1, 1'b0, 1'b0);
      check_ticks("resume_tick", 8, 2);

      // saturation arriving with a start/stop press: sat wins
      r = 1'b1;
      step();
      r = 1'b0;
      step();
      press_go(1'b0, 1'b0, 3'd0);
      chk_outs("sat_start", 3'd1, 1'b1, 1'b0, 1'b0);
      repeat (6) step();
      press_go(1'b0, 1'b1, 3'd1);
      chk_outs("full", 3'd4, 1'b0, 1'b0, 1'b0);
      check_ticks("full_notick", 10, 0);
      press_go(1'b0, 1'b0, 3'd4);
      chk_outs("full_ps_ignored", 3'd4, 1'b0, 1'b0, 1'b0);
      repeat (6) step();
      press_go(1'b1, 1'b0, 3'd4);
      chk_outs("full_clear", 3'd0, 1'b0, 1'b0, 1'b1);
      chk("full_clear.tick", 32'(tick), 32'(0));
      sat = 1'b0;
      step();
      chk("full_clear.clr_next", 32'(clr), 32'(0));
      repeat (5) step();

      // lap keeps ticking, then reset mid-LAP
      press_go(1'b0, 1'b0, 3'd0);
      repeat (6) step();
      press_go(1'b1, 1'b0, 3'd1);
      chk_outs("lap", 3'd2, 1'b1, 1'b1, 1'b0);
      tick_cnt = 0;
      repeat (10) begin
         step();
         if (tick) tick_cnt++;
      end
      chk("lap.tick_count", 32'(tick_cnt), 32'(2));
      r = 1'b1;
      step();
      r = 1'b0;
      chk_outs("reset_lap", 3'd0, 1'b0, 1'b0, 1'b0);
      chk("reset_lap.tick", 32'(tick), 32'(0));
      step();
      chk_outs("reset_lap_after", 3'd0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch BCD counter and display. It debounces the start/stop (`s`) and lap/reset (`l`) push-buttons and runs the run/pause/lap/full state machine. It also generates the 10 ms count-enable tick. Its outputs drive the counter's enable and clear inputs and the display's hold (lap-freeze) input; the counter returns a saturation flag at 99.99.

## Interface
- `TICK_DIV`, default 1_000_000: clk cycles per tick (10 ms at 100 MHz).
- `DB_CYCLES`, default 1_000_000: cycles a synchronized button must be stable before it is accepted.
- `clk` in 1: system clock; the only clock.
- `r` in 1: reset, synchronous, active-high.
- `s` in 1: raw start/stop button, asynchronous, active-high.
- `l` in 1: raw lap/reset button, asynchronous, active-high.
- `sat` in 1: counter at 99.99, level.
- `run` out 1: counter is counting (state RUN or LAP).
- `tick` out 1: one-cycle count enable to the counter, 1/TICK_DIV rate, only while `run`.
- `clr` out 1: one-cycle synchronous clear to the counter.
- `hold` out 1: display shows the frozen lap value (state LAP).
- `st` out 3: current state code, for debug/LEDs.

## Operation
- Each button goes through a 2-FF synchronizer and then a debounce counter.
  - The stable level updates only after the synchronized input differs from it for DB_CYCLES consecutive cycles.
  - Any mismatch-free cycle zeroes the counter.
- On a rising edge of the stable level, the block emits a one-cycle press pulse (`ps`, `pl`). Button release never produces an event.
- States (codes in the package): IDLE=0, RUN=1, LAP=2, PAUSE=3, FULL=4.
- IDLE:
  - `ps` goes to RUN and clears the prescaler.
  - `pl` is ignored.
- RUN:
  - `sat` goes to FULL.
  - Otherwise `ps` goes to PAUSE.
  - Otherwise `pl` goes to LAP.
- LAP:
  - `sat` goes to FULL.
  - Otherwise `ps` goes to PAUSE, and `hold` drops.
  - Otherwise `pl` goes to RUN (the display goes live again).
- PAUSE:
  - `ps` goes to RUN.
  - `pl` goes to IDLE and pulses `clr`.
- FULL:
  - `pl` goes to IDLE and pulses `clr`.
  - `ps` is ignored.
  - `run` is 0.
- Priority in the same cycle is `sat` > `ps` > `pl`. A press that loses is dropped, not queued.
- Prescaler (width $clog2(TICK_DIV)):
  - Counts 0..TICK_DIV-1 only while `run`.
  - `tick`=1 in the cycle it equals TICK_DIV-1, and it wraps to 0 on the next edge.
  - It holds its value in PAUSE, so a pause/resume loses no partial tick.
  - It is zeroed by `r` and on the IDLE→RUN transition.
- `tick` is never asserted in the same cycle as `clr`.

## Timing
- All outputs are registered.
- Reset (`r`=1 at a clk edge) sets:
  - state IDLE, `st`=0;
  - `run`=0, `tick`=0, `clr`=0, `hold`=0;
  - prescaler 0, debounce counters 0, stable levels 0, synchronizers 0.
- Reset mid-operation takes effect on that edge regardless of state or of pending presses. The counter has its own reset from `r`.
- Button latency: raw rise at edge N.
  - Synchronized value at N+2.
  - Stable level rises at N+2+DB_CYCLES.
  - `ps`/`pl` at N+3+DB_CYCLES.
  - The new state and `run`/`hold`/`st` are visible at N+4+DB_CYCLES.
- `clr` is high for exactly the one cycle in which `st` first reads 0 after PAUSE/FULL.
- First `tick` after IDLE→RUN comes TICK_DIV cycles after `run` rises.
- A bounce shorter than DB_CYCLES produces no event.
- A `sat` arriving while in RUN/LAP moves to FULL on the next edge. A `tick` already issued in that cycle is allowed; the counter saturates on its own.

## Structure
- Package `stopwatch_pkg` holds:
  - the state enum (3-bit codes above);
  - the default TICK_DIV and DB_CYCLES localparams shared with the display mux.
- Sub-module `btn_debounce` (params DB_CYCLES; ports clk, r, raw, level, press) contains the synchronizer, counter and edge detector. It is instantiated twice.
- The top level holds the FSM and the prescaler.

## Test plan
All scenarios use TICK_DIV=5, DB_CYCLES=4.
- Reset then idle: hold `r` 2 cycles → all outputs 0 and `st`=0. `pl` pulses in IDLE → no state change.
- Start: clean `s` press at edge 10 → `st`=1 and `run`=1 at edge 18. `tick` at edges 23, 28, 33 (period 5).
- Bounce: `s` toggled with 3-cycle highs ×4 → no `ps`, `st` stays 0. Then a 6-cycle high → exactly one transition.
- Pause accuracy: RUN with prescaler at 2, press `s` → PAUSE, prescaler frozen at its value. Press `s` again → first `tick` 3 − (cycles already counted) cycles after `run` rises, i.e. no tick lost or duplicated.
- Lap then reset: in RUN, `pl` → `st`=2 and `hold`=1 while `tick` continues. `pl` → `st`=1 and `hold`=0. `ps` → `st`=3. `pl` → `st`=0 with `clr`=1 for one cycle.
- Saturation and priority: in RUN, assert `sat` in the same cycle as `ps` → `st`=4 and `run`=0, no further `tick`. `ps` ignored. `pl` → IDLE with `clr` pulse. `r` asserted mid-LAP → IDLE on the next edge.
